// File: rtl/mux_lane_merge_pkg.sv
// mux_lane_merge_pkg: shared widths, lane indices and reset values for the lane merger
package mux_lane_merge_pkg;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = $clog2(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] RST_DATA = '0;
    typedef enum logic {LANE_0 = 1'b0, LANE_1 = 1'b1} lane_e;
    function automatic lane_e other_lane(input lane_e l);
        return (l == LANE_0) ? LANE_1 : LANE_0;
    endfunction
endpackage

// File: rtl/mux_lane_merge_if.sv
// mux_lane_merge_if: two valid-qualified input lanes plus merged stream and status
interface mux_lane_merge_if #(parameter int DATA_W = mux_lane_merge_pkg::DATA_W);
    logic [DATA_W-1:0] data_lane_0;
    logic              valid_lane_0;
    logic [DATA_W-1:0] data_lane_1;
    logic              valid_lane_1;
    logic [DATA_W-1:0] data_mux;
    logic              valid_mux;
    logic              fifo_full_0;
    logic              fifo_full_1;
    logic              overflow_err;
    modport master (
        output data_lane_0, valid_lane_0, data_lane_1, valid_lane_1,
        input  data_mux, valid_mux, fifo_full_0, fifo_full_1, overflow_err
    );
    modport slave (
        input  data_lane_0, valid_lane_0, data_lane_1, valid_lane_1,
        output data_mux, valid_mux, fifo_full_0, fifo_full_1, overflow_err
    );
endinterface

// File: rtl/mux_lane_merge_lane_fifo.sv
// lane_fifo: per-lane skew FIFO; a pop frees the slot a same-cycle push into a full FIFO needs
module lane_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic              overflow
);
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
    assign head_data = mem_q[rd_ptr_q];
    assign overflow  = push && full && !do_pop;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: entries are only read once count covers them
    always_ff @(posedge clk_2f) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/mux_lane_merge.sv
// mux_lane_merge: re-interleaves two skewed byte lanes in strict 0,1,0,1 order onto one registered stream
module mux_lane_merge #(
    parameter int DATA_W     = mux_lane_merge_pkg::DATA_W,
    parameter int FIFO_DEPTH = mux_lane_merge_pkg::FIFO_DEPTH,
    parameter int ADDR_W     = mux_lane_merge_pkg::ADDR_W
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    mux_lane_merge_if.slave       bus
);
    import mux_lane_merge_pkg::*;

    lane_e             sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d, head_0, head_1;
    logic              valid_q, valid_d, err_q, err_d, avail;
    logic              empty_0, empty_1, full_0, full_1, ovf_0, ovf_1;

    lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_fifo_0 (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .push      (bus.valid_lane_0),
        .push_data (bus.data_lane_0),
        .pop       (sel_q == LANE_0),
        .head_data (head_0),
        .empty     (empty_0),
        .full      (full_0),
        .overflow  (ovf_0)
    );

    lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_fifo_1 (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .push      (bus.valid_lane_1),
        .push_data (bus.data_lane_1),
        .pop       (sel_q == LANE_1),
        .head_data (head_1),
        .empty     (empty_1),
        .full      (full_1),
        .overflow  (ovf_1)
    );

    // selector only advances when its lane supplies a byte, so order never slips
    always_comb begin
        avail   = (sel_q == LANE_0) ? !empty_0 : !empty_1;
        sel_d   = avail ? other_lane(sel_q) : sel_q;
        valid_d = avail;
        data_d  = avail ? ((sel_q == LANE_0) ? head_0 : head_1) : data_q;
        err_d   = err_q || ovf_0 || ovf_1;
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            sel_q   <= LANE_0;
            data_q  <= DATA_W'(RST_DATA);
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_mux     = data_q;
    assign bus.valid_mux    = valid_q;
    assign bus.fifo_full_0  = full_0;
    assign bus.fifo_full_1  = full_1;
    assign bus.overflow_err = err_q;
endmodule

// File: tb/tb_mux_lane_merge.sv
// tb_mux_lane_merge: queue-based reference model, per-cycle compare, directed scenarios and random traffic
module tb_mux_lane_merge;
    import mux_lane_merge_pkg::*;

    logic clk_2f = 1'b0;
    logic reset  = 1'b0;
    always #5 clk_2f = ~clk_2f;

    mux_lane_merge_if bus ();
    mux_lane_merge dut (.clk_2f(clk_2f), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$], q1[$];
    int         m_sel   = 0;
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;

    logic [7:0] out_log[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: a lane queue pops only on its turn, pushes succeed while fewer than FIFO_DEPTH remain
    always @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            m_sel = 0; m_data = 8'h00; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            if (m_sel == 0 && q0.size() > 0) begin
                m_data = q0.pop_front(); m_valid = 1'b1; m_sel = 1;
            end else if (m_sel == 1 && q1.size() > 0) begin
                m_data = q1.pop_front(); m_valid = 1'b1; m_sel = 0;
            end else m_valid = 1'b0;
            if (bus.valid_lane_0) begin
                if (q0.size() < FIFO_DEPTH) q0.push_back(bus.data_lane_0); else m_err = 1'b1;
            end
            if (bus.valid_lane_1) begin
                if (q1.size() < FIFO_DEPTH) q1.push_back(bus.data_lane_1); else m_err = 1'b1;
            end
        end
    end

    always @(negedge clk_2f) begin
        chk("valid_mux", 32'(bus.valid_mux), 32'(m_valid));
        chk("data_mux", 32'(bus.data_mux), 32'(m_data));
        chk("fifo_full_0", 32'(bus.fifo_full_0), 32'(q0.size() == FIFO_DEPTH));
        chk("fifo_full_1", 32'(bus.fifo_full_1), 32'(q1.size() == FIFO_DEPTH));
        chk("overflow_err", 32'(bus.overflow_err), 32'(m_err));
        if (!reset && bus.valid_mux) out_log.push_back(bus.data_mux);
    end

    task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        bus.valid_lane_0 = v0; bus.data_lane_0 = d0;
        bus.valid_lane_1 = v1; bus.data_lane_1 = d1;
        @(negedge clk_2f); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        bus.valid_lane_0 = 1'b0; bus.valid_lane_1 = 1'b0;
        reset = 1'b1;
        @(negedge clk_2f); #1;
        reset = 1'b0;
        out_log.delete();
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
            chk(name, 32'(out_log[i]), 32'(exp_q[i]));
    endtask

    initial begin
        bus.valid_lane_0 = 1'b0; bus.data_lane_0 = 8'h00;
        bus.valid_lane_1 = 1'b0; bus.data_lane_1 = 8'h00;
        #1 reset = 1'b1;
        @(negedge clk_2f); #1;
        chk("rst_data", 32'(bus.data_mux), 32'h0);
        chk("rst_valid", 32'(bus.valid_mux), 32'h0);
        chk("rst_err", 32'(bus.overflow_err), 32'h0);
        reset = 1'b0;

        do_reset();
        step(1'b1, 8'hA0, 1'b1, 8'hB0);
        step(1'b1, 8'hA1, 1'b1, 8'hB1);
        step(1'b1, 8'hA2, 1'b1, 8'hB2);
        idle(6);
        exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
        check_log("aligned");
        chk("aligned_err", 32'(bus.overflow_err), 32'h0);

        do_reset();
        step(1'b0, 8'h00, 1'b1, 8'h11);
        step(1'b0, 8'h00, 1'b1, 8'h22);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        chk("skew_wait", 32'(out_log.size()), 32'h0);
        step(1'b1, 8'h01, 1'b0, 8'h00);
        step(1'b1, 8'h02, 1'b0, 8'h00);
        idle(5);
        exp_q = '{8'h01, 8'h11, 8'h02, 8'h22};
        check_log("skew");

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'(8'h50 + i));
            if (i == 3) chk("ovf_full1", 32'(bus.fifo_full_1), 32'h1);
        end
        chk("ovf_err_set", 32'(bus.overflow_err), 32'h1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 8'h00);
        idle(8);
        exp_q = '{8'h00, 8'h50, 8'h01, 8'h51, 8'h02, 8'h52, 8'h03, 8'h53};
        check_log("ovf");
        chk("ovf_err_sticky", 32'(bus.overflow_err), 32'h1);

        do_reset();
        step(1'b1, 8'h10, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 8'h00);
        chk("full0_set", 32'(bus.fifo_full_0), 32'h1);
        step(1'b0, 8'h00, 1'b1, 8'h30);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b1, 8'h24, 1'b0, 8'h00);
        chk("fullpop_full0", 32'(bus.fifo_full_0), 32'h1);
        chk("fullpop_err", 32'(bus.overflow_err), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 8'(8'h40 + i));
        idle(8);
        exp_q = '{8'h10, 8'h30, 8'h20, 8'h40, 8'h21, 8'h41, 8'h22, 8'h42, 8'h23, 8'h43, 8'h24};
        check_log("fullpop");

        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE0 + i), 1'b1, 8'(8'hF0 + i));
        chk("midrst_pre_valid", 32'(bus.valid_mux), 32'h1);
        bus.valid_lane_0 = 1'b0; bus.valid_lane_1 = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_data", 32'(bus.data_mux), 32'h0);
        chk("midrst_valid", 32'(bus.valid_mux), 32'h0);
        @(negedge clk_2f); #1;
        reset = 1'b0;
        out_log.delete();
        step(1'b1, 8'hC0, 1'b1, 8'hD0);
        idle(5);
        exp_q = '{8'hC0, 8'hD0};
        check_log("midrst");

        do_reset();
        step(1'b1, 8'h7E, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b0, 8'h00);
            chk("hold_valid", 32'(bus.valid_mux), 32'h0);
            chk("hold_data", 32'(bus.data_mux), 32'h7E);
        end
        step(1'b1, 8'h44, 1'b1, 8'h33);
        idle(4);
        exp_q = '{8'h7E, 8'h33, 8'h44};
        check_log("hold");

        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            int p0 = $urandom_range(10, 100);
            int p1 = $urandom_range(10, 100);
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 299) == 0) begin
                    bus.valid_lane_0 = 1'b0; bus.valid_lane_1 = 1'b0;
                    reset = 1'b1;
                    @(negedge clk_2f); #1;
                    reset = 1'b0;
                end else begin
                    step($urandom_range(0, 99) < p0, 8'($urandom),
                         $urandom_range(0, 99) < p1, 8'($urandom));
                end
            end
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
